// File: rtl/rom_download_writer.sv
// Converts the data_io ROM byte stream into 16-bit SDRAM word writes over a
// toggle req/ack port, with a small request FIFO and a ROM-loaded flag.
module rom_download_writer #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ROM_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t      state, state_nx;
  logic        wr_prev, active_prev;
  logic        active, active_rise, byte_acc;
  req_t        hold, new_byte, push_entry;
  logic        hold_valid, hold_load, hold_clear, merge;
  logic        push, push_ok, issue, port_idle;
  req_t        fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, enter_load;
  logic        unused_addr_msb;

  assign unused_addr_msb = ioctl_addr[24];

  assign active      = ioctl_download && (ioctl_index == ROM_INDEX);
  assign active_rise = active && !active_prev;
  assign byte_acc    = ioctl_wr && !wr_prev && active;

  assign new_byte = '{addr: ioctl_addr[23:1],
                      ds:   {ioctl_addr[0], ~ioctl_addr[0]},
                      data: {ioctl_dout, ioctl_dout}};

  // An odd byte completes the word only when the held byte is its even partner.
  assign merge = hold_valid && (hold.ds == 2'b01) && ioctl_addr[0] &&
                 (ioctl_addr[23:1] == hold.addr);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign port_idle  = (port_req == port_ack);
  assign issue      = port_idle && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok    = push && (!fifo_full || issue);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push       = 1'b0;
    push_entry = hold;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (byte_acc) begin
      if (merge) begin
        push       = 1'b1;
        push_entry = '{addr: hold.addr, ds: 2'b11, data: {ioctl_dout, hold.data[7:0]}};
        hold_clear = 1'b1;
      end else begin
        push      = hold_valid;
        hold_load = 1'b1;
      end
    end else if (state == FLUSH && hold_valid) begin
      push       = 1'b1;
      hold_clear = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (active_rise) state_nx = LOAD;
      LOAD:  if (!active) state_nx = FLUSH;
      FLUSH: if (!hold_valid && fifo_empty && port_idle) state_nx = DONE;
      DONE:  if (active_rise) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_load = (state != LOAD) && (state_nx == LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_prev     <= 1'b0;
      active_prev <= 1'b0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      port_req    <= 1'b0;
      port_a      <= '0;
      port_ds     <= '0;
      port_d      <= '0;
      rom_loaded  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_prev     <= ioctl_wr;
      active_prev <= active;

      if (hold_load) begin
        hold       <= new_byte;
        hold_valid <= 1'b1;
      end else if (hold_clear) begin
        hold_valid <= 1'b0;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;

      if (issue) begin
        port_a   <= fifo_mem[rd_ptr[AW-1:0]].addr;
        port_ds  <= fifo_mem[rd_ptr[AW-1:0]].ds;
        port_d   <= fifo_mem[rd_ptr[AW-1:0]].data;
        rd_ptr   <= rd_ptr + 1'b1;
        port_req <= ~port_req;
      end

      if (enter_load) overflow <= 1'b0;
      else if (push && !push_ok) overflow <= 1'b1;

      if (enter_load) rom_loaded <= 1'b0;
      else if (state == FLUSH && state_nx == DONE) rom_loaded <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign port_we = (state == LOAD) || (state == FLUSH);
  assign busy    = hold_valid || !fifo_empty || !port_idle;

endmodule

// File: tb/tb_rom_download_writer.sv
// Bench for rom_download_writer: an SDRAM port responder records requests and
// they are compared with word writes derived from the downloaded byte list.
module tb_rom_download_writer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we, rom_loaded, busy, overflow;

  rom_download_writer #(.DEPTH(4), .ROM_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .port_we(port_we),
    .rom_loaded(rom_loaded), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wreq_t;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  b;
  } byte_t;

  wreq_t obs_q[$];
  logic  obs_we_q[$];
  wreq_t exp_q[$];
  byte_t bytes_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int ack_dly = 2;
  bit ack_en = 1'b1;
  int ack_cnt = 0;
  bit captured = 1'b0;

  // SDRAM port model: records each request once, acks ack_dly cycles later.
  always begin
    @(posedge clk_sys or negedge reset_n);
    if (!reset_n) begin
      port_ack = 1'b0;
      captured = 1'b0;
      ack_cnt  = 0;
    end else begin
      #2;
      if (port_req !== port_ack) begin
        if (!captured) begin
          obs_q.push_back('{a: port_a, ds: port_ds, d: port_d});
          obs_we_q.push_back(port_we);
          captured = 1'b1;
        end
        if (ack_en) begin
          ack_cnt++;
          if (ack_cnt >= ack_dly) begin
            port_ack = port_req;
            ack_cnt  = 0;
            captured = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [23:0] a, input logic [7:0] b,
                           input int hi, input int lo);
    ioctl_addr = {1'b0, a};
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    if (ioctl_download && ioctl_index == 8'd0) bytes_q.push_back('{a: a, b: b});
    repeat (hi) tick();
    ioctl_wr = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic start_download(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    tick();
  endtask

  // Even byte at 2k followed directly by byte 2k+1 forms one word write;
  // every other byte becomes a single-byte write with its lane enable.
  function automatic void build_expected();
    int i;
    logic [23:0] a;
    exp_q.delete();
    i = 0;
    while (i < bytes_q.size()) begin
      a = bytes_q[i].a;
      if (!a[0] && (i + 1 < bytes_q.size()) && (bytes_q[i+1].a == a + 24'd1)) begin
        exp_q.push_back('{a: a[23:1], ds: 2'b11, d: {bytes_q[i+1].b, bytes_q[i].b}});
        i += 2;
      end else begin
        exp_q.push_back('{a: a[23:1], ds: (a[0] ? 2'b10 : 2'b01),
                          d: {bytes_q[i].b, bytes_q[i].b}});
        i += 1;
      end
    end
  endfunction

  task automatic compare_requests(input string name);
    int n;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s request count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_we_q[i] !== 1'b1) begin
        n_err++;
        $display("FAIL %s req[%0d]: got a=%h ds=%b d=%h we=%b expected a=%h ds=%b d=%h we=1",
                 name, i, obs_q[i].a, obs_q[i].ds, obs_q[i].d, obs_we_q[i],
                 exp_q[i].a, exp_q[i].ds, exp_q[i].d);
      end
    end
    obs_q.delete();
    obs_we_q.delete();
    exp_q.delete();
    bytes_q.delete();
  endtask

  task automatic wait_loaded(input string name, input int budget);
    int k = 0;
    while (rom_loaded !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (rom_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL %s rom_loaded timeout: got %b expected 1 within %0d cycles", name, rom_loaded, budget);
    end else if (busy !== 1'b0 || port_we !== 1'b0) begin
      n_err++;
      $display("FAIL %s done state: got busy=%b we=%b expected busy=0 we=0", name, busy, port_we);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if ({port_req, port_a, port_ds, port_d, port_we, rom_loaded, busy, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset values: got req=%b a=%h ds=%b d=%h we=%b loaded=%b busy=%b ovf=%b expected all 0",
               port_req, port_a, port_ds, port_d, port_we, rom_loaded, busy, overflow);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_wrong_index();
    start_download(8'd1);
    for (int i = 0; i < 4; i++) send_byte(24'(i), 8'(8'h50 + i), 1, 3);
    end_download();
    repeat (20) tick();
    n_cmp++;
    if (port_req !== 1'b0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL wrong_index requests: got req=%b count=%0d expected req=0 count=0", port_req, obs_q.size());
    end
    n_cmp++;
    if (rom_loaded !== 1'b0 || port_we !== 1'b0) begin
      n_err++;
      $display("FAIL wrong_index state: got loaded=%b we=%b expected 0 0", rom_loaded, port_we);
    end
  endtask

  task automatic test_sequential_merge();
    logic req0;
    ack_dly = 4;
    start_download(8'd0);
    send_byte(24'd0, 8'h11, 1, 3);
    req0 = port_req;
    ioctl_addr = 25'd1;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    bytes_q.push_back('{a: 24'd1, b: 8'h22});
    tick();
    n_cmp++;
    if (port_req !== req0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL push_latency: got req=%b busy=%b expected req=%b busy=1", port_req, busy, req0);
    end
    tick();
    n_cmp++;
    if (port_req !== ~req0) begin
      n_err++;
      $display("FAIL issue_latency: got req=%b expected %b", port_req, ~req0);
    end
    ioctl_wr = 1'b0;
    repeat (3) tick();
    send_byte(24'd2, 8'h33, 1, 3);
    send_byte(24'd3, 8'h44, 1, 3);
    end_download();
    wait_loaded("seq_merge", 200);
    exp_q.delete();
    exp_q.push_back('{a: 23'd0, ds: 2'b11, d: 16'h2211});
    exp_q.push_back('{a: 23'd1, ds: 2'b11, d: 16'h4433});
    compare_requests("seq_merge");
  endtask

  task automatic test_unaligned();
    ack_dly = 2;
    start_download(8'd0);
    send_byte(24'd5, 8'hAA, 1, 3);
    // strobe edge on the last active cycle: download drops right after it
    ioctl_addr = 25'd8;
    ioctl_dout = 8'hBB;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick();
    wait_loaded("unaligned", 200);
    exp_q.delete();
    exp_q.push_back('{a: 23'd2, ds: 2'b10, d: 16'hAAAA});
    exp_q.push_back('{a: 23'd4, ds: 2'b01, d: 16'hBBBB});
    compare_requests("unaligned");
  endtask

  task automatic test_backpressure();
    int k;
    ack_en  = 1'b0;
    ack_dly = 3;
    start_download(8'd0);
    for (int w = 0; w < 8; w++) begin
      send_byte(24'(2 * w), 8'($urandom), 1, 1);
      send_byte(24'(2 * w + 1), 8'($urandom), 1, 1);
    end
    end_download();
    repeat (10) tick();
    n_cmp++;
    if (overflow !== 1'b1 || busy !== 1'b1 || obs_q.size() != 1) begin
      n_err++;
      $display("FAIL backpressure stall: got ovf=%b busy=%b issued=%0d expected ovf=1 busy=1 issued=1",
               overflow, busy, obs_q.size());
    end
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      do begin
        @(posedge clk_sys);
        #3;
        k++;
      end while (port_req !== port_ack && k < 20);
      @(posedge clk_sys);
      #1;
      n_cmp++;
      if ((i < 4) ? (port_req === port_ack) : (port_req !== port_ack)) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got req=%b ack=%b expected new request=%0d", i, port_req, port_ack, (i < 4));
      end
    end
    wait_loaded("backpressure", 200);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow sticky: got %b expected 1", overflow);
    end
    build_expected();
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    compare_requests("backpressure");
  endtask

  task automatic test_reload();
    n_cmp++;
    if (rom_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL reload before: got loaded=%b expected 1", rom_loaded);
    end
    ack_dly = 2;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    n_cmp++;
    if (rom_loaded !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reload start: got loaded=%b ovf=%b expected 0 0", rom_loaded, overflow);
    end
    tick();
    for (int i = 0; i < 4; i++) send_byte(24'(24'h100 + i), 8'($urandom), 1, 4);
    end_download();
    wait_loaded("reload", 200);
    build_expected();
    compare_requests("reload");
  endtask

  task automatic test_reset_mid_load();
    ack_dly = 2;
    start_download(8'd0);
    for (int i = 0; i < 3; i++) send_byte(24'(i), 8'(8'hC0 + i), 1, 2);
    @(negedge clk_sys);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    n_cmp++;
    if ({port_req, port_a, port_ds, port_d, port_we, rom_loaded, busy, overflow} !== '0) begin
      n_err++;
      $display("FAIL async reset: got req=%b a=%h ds=%b d=%h we=%b loaded=%b busy=%b ovf=%b expected all 0",
               port_req, port_a, port_ds, port_d, port_we, rom_loaded, busy, overflow);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    obs_q.delete();
    obs_we_q.delete();
    bytes_q.delete();
    start_download(8'd0);
    for (int i = 0; i < 6; i++) send_byte(24'(24'h40 + i), 8'($urandom), 1, 4);
    end_download();
    wait_loaded("reset_redownload", 200);
    build_expected();
    compare_requests("reset_redownload");
  endtask

  task automatic test_random();
    int n;
    logic [23:0] addr;
    for (int t = 0; t < 6; t++) begin
      ack_dly = $urandom_range(1, 3);
      start_download(8'd0);
      n    = $urandom_range(8, 16);
      addr = 24'($urandom);
      for (int i = 0; i < n; i++) begin
        send_byte(addr, 8'($urandom), $urandom_range(1, 2), $urandom_range(6, 8));
        if ($urandom_range(0, 3) != 0) addr = addr + 24'd1;
        else addr = addr + 24'($urandom_range(2, 5));
      end
      end_download();
      wait_loaded("random", 300);
      n_cmp++;
      if (overflow !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d] overflow: got %b expected 0", t, overflow);
      end
      build_expected();
      compare_requests("random");
    end
  endtask

  initial begin
    test_reset();
    test_wrong_index();
    test_sequential_merge();
    test_unaligned();
    test_backpressure();
    test_reload();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
